// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared mode encodings and default widths for accum_datapath
package datapath_pkg;

  localparam logic [1:0] MODE_ADD  = 2'b00;
  localparam logic [1:0] MODE_ACC  = 2'b01;
  localparam logic [1:0] MODE_SUB  = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_ACC_W = 10;

endpackage

// File: rtl/rc_adder.sv
// rtl/rc_adder.sv - N-bit ripple-carry adder
module rc_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic carry;

  // ripple the carry from bit 0 upward, one full adder per bit
  always_comb begin
    sum   = '0;
    carry = cin;
    for (int i = 0; i < N; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
    end
    cout = carry;
  end

endmodule

// File: rtl/accum_datapath.sv
// rtl/accum_datapath.sv - two-stage add/accumulate/subtract datapath; DATAPATH_SAT_EN selects clamping instead of wrap
module accum_datapath
  import datapath_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [1:0]       select,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             clr,
  output logic [ACC_W-1:0] S,
  output logic             valid,
  output logic             ovf
);

  // stage-1 registers
  logic [ACC_W-1:0] sum1_q, sum1_d;
  logic [1:0]       sel_q, sel_d;
  logic             s1_v_q, s1_v_d;

  // stage-2 registers
  logic [ACC_W-1:0] s_q, s_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;

  // operand adder
  logic [WIDTH-1:0] sum1_raw;
  logic             cout1;
  logic [ACC_W-1:0] sum1_ext;

  rc_adder #(.N(WIDTH)) u_add1 (
    .a    (A),
    .b    (B),
    .cin  (Cin),
    .sum  (sum1_raw),
    .cout (cout1)
  );

  assign sum1_ext = ACC_W'({cout1, sum1_raw});

  // accumulator adder; subtraction is S + ~sum1 + 1, so carry-out low means borrow
  logic [ACC_W-1:0] b2;
  logic             cin2;
  logic [ACC_W-1:0] sum2;
  logic             cout2;

  assign cin2 = (sel_q == MODE_SUB);
  assign b2   = cin2 ? ~sum1_q : sum1_q;

  rc_adder #(.N(ACC_W)) u_add2 (
    .a    (s_q),
    .b    (b2),
    .cin  (cin2),
    .sum  (sum2),
    .cout (cout2)
  );

  // stage 1: capture operand sum and mode on load
  always_comb begin
    sum1_d = sum1_q;
    sel_d  = sel_q;
    s1_v_d = load;
    if (load) begin
      sum1_d = sum1_ext;
      sel_d  = select;
    end
  end

  // stage 2: apply the captured op to S; clr wins over any op landing this edge
  always_comb begin
    s_d     = s_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    if (clr) begin
      s_d   = '0;
      ovf_d = 1'b0;
    end else if (s1_v_q) begin
      valid_d = 1'b1;
      case (sel_q)
        MODE_ADD: s_d = sum1_q;
        MODE_ACC: begin
          s_d = sum2;
          if (cout2) begin
            ovf_d = 1'b1;
`ifdef DATAPATH_SAT_EN
            s_d = '1;
`endif
          end
        end
        MODE_SUB: begin
          s_d = sum2;
          if (!cout2) begin
            ovf_d = 1'b1;
`ifdef DATAPATH_SAT_EN
            s_d = '0;
`endif
          end
        end
        default: s_d = s_q;
      endcase
    end
  end

  // pipeline registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sum1_q  <= '0;
      sel_q   <= MODE_ADD;
      s1_v_q  <= 1'b0;
      s_q     <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sum1_q  <= sum1_d;
      sel_q   <= sel_d;
      s1_v_q  <= s1_v_d;
      s_q     <= s_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign S     = s_q;
  assign valid = valid_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_accum_datapath.sv
// tb/tb_accum_datapath.sv - randomized and directed self-check of accum_datapath against an arithmetic model
module tb_accum_datapath;

  localparam int WIDTH = 4;
  localparam int ACC_W = 10;
  localparam int MODV  = 1 << ACC_W;

  logic             clk = 1'b0;
  logic             rst, load, Cin, clr;
  logic [1:0]       select;
  logic [WIDTH-1:0] A, B;
  logic [ACC_W-1:0] S;
  logic             valid, ovf;

  int n_vec = 0;
  int n_err = 0;

  // model state: result, flags, and the one operation waiting for stage 2
  int m_s = 0, m_valid = 0, m_ovf = 0;
  int p_v = 0, p_sum = 0, p_sel = 0;

  always #5 clk = ~clk;

  accum_datapath #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .select (select),
    .A      (A),
    .B      (B),
    .Cin    (Cin),
    .clr    (clr),
    .S      (S),
    .valid  (valid),
    .ovf    (ovf)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int t;
    if (rst) begin
      m_s = 0; m_ovf = 0; m_valid = 0; p_v = 0; p_sum = 0; p_sel = 0;
    end else begin
      if (clr) begin
        m_s = 0; m_ovf = 0; m_valid = 0;
      end else if (p_v != 0) begin
        m_valid = 1;
        case (p_sel)
          0: m_s = p_sum;
          1: begin
            t = m_s + p_sum;
            if (t >= MODV) begin
              m_ovf = 1;
`ifdef DATAPATH_SAT_EN
              m_s = MODV - 1;
`else
              m_s = t - MODV;
`endif
            end else m_s = t;
          end
          2: begin
            if (p_sum > m_s) begin
              m_ovf = 1;
`ifdef DATAPATH_SAT_EN
              m_s = 0;
`else
              m_s = m_s - p_sum + MODV;
`endif
            end else m_s = m_s - p_sum;
          end
          default: ;
        endcase
      end else m_valid = 0;
      p_v = load;
      if (load) begin
        p_sum = int'(A) + int'(B) + int'(Cin);
        p_sel = int'(select);
      end
    end
  endtask

  task automatic step(input logic r, input logic c, input logic l, input logic [1:0] sel,
                      input int a, input int b, input logic ci);
    rst = r; clr = c; load = l; select = sel;
    A = WIDTH'(a); B = WIDTH'(b); Cin = ci;
    @(posedge clk);
    model_edge();
    #1;
    check_eq("S", int'(S), m_s);
    check_eq("valid", int'(valid), m_valid);
    check_eq("ovf", int'(ovf), m_ovf);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 2'b00, 0, 0, 1'b0);
  endtask

  initial begin
    // 1. reset and quiet cycles
    step(1'b1, 1'b0, 1'b0, 2'b00, 0, 0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 2'b00, 0, 0, 1'b0);
    check_eq("rst_S", int'(S), 0);
    check_eq("rst_valid", int'(valid), 0);
    check_eq("rst_ovf", int'(ovf), 0);
    for (int i = 0; i < 5; i++) begin
      idle();
      check_eq("quiet_valid", int'(valid), 0);
    end

    // 2. back-to-back ADDs
    step(1'b0, 1'b0, 1'b1, 2'b00, 1, 5, 1'b0);
    check_eq("add_latency_valid", int'(valid), 0);
    step(1'b0, 1'b0, 1'b1, 2'b00, 8, 7, 1'b1);
    check_eq("add1_S", int'(S), 6);
    check_eq("add1_valid", int'(valid), 1);
    idle();
    check_eq("add2_S", int'(S), 16);
    check_eq("add2_valid", int'(valid), 1);
    check_eq("add2_ovf", int'(ovf), 0);
    idle();
    check_eq("add_done_valid", int'(valid), 0);

    // 3. accumulate to the top and past it
    step(1'b0, 1'b1, 1'b0, 2'b00, 0, 0, 1'b0);
    for (int i = 0; i < 33; i++) step(1'b0, 1'b0, 1'b1, 2'b01, 15, 15, 1'b1);
    idle();
    check_eq("acc33_S", int'(S), 1023);
    check_eq("acc33_ovf", int'(ovf), 0);
    step(1'b0, 1'b0, 1'b1, 2'b01, 15, 15, 1'b1);
    idle();
`ifdef DATAPATH_SAT_EN
    check_eq("acc34_S", int'(S), 1023);
`else
    check_eq("acc34_S", int'(S), 30);
`endif
    check_eq("acc34_ovf", int'(ovf), 1);

    // 4. subtract below zero, then HOLD
    step(1'b0, 1'b1, 1'b0, 2'b00, 0, 0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 2'b00, 1, 5, 1'b0);
    step(1'b0, 1'b0, 1'b1, 2'b10, 7, 7, 1'b0);
    check_eq("sub_pre_S", int'(S), 6);
    step(1'b0, 1'b0, 1'b1, 2'b11, 2, 3, 1'b0);
`ifdef DATAPATH_SAT_EN
    check_eq("sub_S", int'(S), 0);
`else
    check_eq("sub_S", int'(S), 1016);
`endif
    check_eq("sub_ovf", int'(ovf), 1);
    idle();
`ifdef DATAPATH_SAT_EN
    check_eq("hold_S", int'(S), 0);
`else
    check_eq("hold_S", int'(S), 1016);
`endif
    check_eq("hold_valid", int'(valid), 1);

    // 5. clr drops the op landing on it; load with clr still captures
    step(1'b0, 1'b0, 1'b1, 2'b01, 1, 1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 2'b00, 3, 4, 1'b0);
    check_eq("clr_S", int'(S), 0);
    check_eq("clr_valid", int'(valid), 0);
    check_eq("clr_ovf", int'(ovf), 0);
    idle();
    check_eq("clr_load_S", int'(S), 7);
    check_eq("clr_load_valid", int'(valid), 1);

    // 6. reset discards an in-flight op and the sticky flag
    step(1'b0, 1'b0, 1'b1, 2'b10, 7, 7, 1'b0);
    idle();
    check_eq("pre_rst_ovf", int'(ovf), 1);
    step(1'b0, 1'b0, 1'b1, 2'b00, 2, 2, 1'b0);
    step(1'b1, 1'b0, 1'b0, 2'b00, 0, 0, 1'b0);
    check_eq("rst_mid_S", int'(S), 0);
    check_eq("rst_mid_ovf", int'(ovf), 0);
    idle();
    check_eq("rst_mid_valid", int'(valid), 0);
    check_eq("rst_mid_S2", int'(S), 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(63) == 0), ($urandom_range(15) == 0), ($urandom_range(3) != 0),
           2'($urandom_range(3)), int'($urandom_range(15)), int'($urandom_range(15)),
           1'($urandom_range(1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
